data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024; number of 32-bit words in the array (4 KB), power of two.
REQ-002 Parameter WAIT_CYCLES, default 2; wait-state cycles between acceptance and response, range 0..15.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 addr  input  32  byte address from the CPU data port.
REQ-006 ren  input  1  read request, level.
REQ-007 wen  input  1  write request, level.
REQ-008 din  input  32  write data, already lane-aligned by the CPU.
REQ-009 byte_select  input  4  per-byte write enables; bit i enables din[8i+7:8i].
REQ-010 dout  output  32  read data, the full aligned word.
REQ-011 mem_ready  output  1  high when no access is pending or an access completes; CPU stalls while low.
REQ-012 err  output  1  access error, present only with DMEM_ERR_EN.

Function
REQ-013 FSM states: IDLE, WAIT, DONE.
REQ-014 IDLE with ren|wen=1 SHALL accept the request: latch addr, din, byte_select and op on that edge.
  - If WAIT_CYCLES>0, go to WAIT with counter=WAIT_CYCLES-1.
  - Else go to DONE.
REQ-015 mem_ready SHALL be combinational: 1 in IDLE with ren|wen=0, 1 in DONE, 0 otherwise, including the IDLE acceptance cycle.
REQ-016 WAIT SHALL decrement the counter each cycle and go to DONE on the edge where the counter equals 0.
REQ-017 The edge entering DONE SHALL do the following:
  - Write: store the latched din bytes whose byte_select bit is 1; other bytes are unchanged.
  - Read: load dout with the word at latched addr[log2(DEPTH_WORDS)+1:2].
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE. A new request is accepted no earlier than the cycle after DONE.
REQ-019 Latency: accept at cycle T gives mem_ready=1 at cycle T+1+WAIT_CYCLES.
REQ-020 dout SHALL hold its value until the next read completes; writes do not alter dout.
REQ-021 ren and wen both 1 at acceptance: perform the write only, with no dout update.
REQ-022 A write with byte_select=4'b0000 completes normally and modifies nothing.
REQ-023 addr[1:0] is ignored for array indexing. Address bits above the array index wrap, so the array is aliased.
REQ-024 Changes on addr, din, ren or wen during WAIT or DONE SHALL be ignored.

Reset
REQ-025 On reset=0, asynchronously:
  - State goes to IDLE, counter=0, dout=32'h0, err=0.
  - All latched request registers are cleared.
REQ-026 Reset during WAIT SHALL abort the access: no array write occurs.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_ERR_EN controls error detection.
REQ-029 With DMEM_ERR_EN defined:
  - err SHALL be asserted during DONE only, for two cases:
    - any latched address bit at or above log2(DEPTH_WORDS)+2 is 1;
    - both ren and wen were 1 at acceptance.
  - An erroring write SHALL be suppressed.
  - An erroring read SHALL return 32'h0.
REQ-030 Without DMEM_ERR_EN:
  - The err port is absent.
  - Aliasing per REQ-023 applies.
  - Write-priority per REQ-021 applies.

Structure
REQ-031 Shared package dmem_pkg SHALL hold:
  - the FSM state encoding (IDLE/WAIT/DONE);
  - the 4-bit wait-counter width constant;
  - the 32-bit data-width constant.
REQ-032 One sub-module dmem_bram: synchronous single-port byte-enable RAM (DEPTH_WORDS x 32, 4 write enables, registered read).
REQ-033 The FSM, counter, request latches and error logic SHALL remain in data_mem_responder.

Verification
REQ-034 Bench SHALL cover each scenario below:
  - Reset, then idle: mem_ready=1, dout=0.
  - WAIT_CYCLES=2:
    - Write addr=0x10, din=0xDEADBEEF, be=4'b1111 -> mem_ready low 3 cycles, high 1 cycle.
    - Then read addr=0x10 -> dout=0xDEADBEEF exactly 3 cycles after acceptance.
  - Partial write to word 0x10, din=0x000000AA, be=4'b0001 -> subsequent read returns 0xDEADBEAA.
  - WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4 -> mem_ready pattern 0,1,0,1; dout follows per access.
  - Reset asserted mid-WAIT of a write to 0x20 with din=0x12345678 -> state IDLE; later read of 0x20 returns its prior value.
  - DMEM_ERR_EN, DEPTH_WORDS=1024:
    - Read addr=0x00001000 -> err=1 in DONE, dout=0.
    - Without the macro, the same read returns the word at 0x0.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder:
//               FSM state encoding, wait-counter width, data width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam int c_DATA_W = 32;
  localparam int c_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
// ============================================================================
// Module      : data_mem_responder_if
// Description : CPU data-port bus between a CPU (master) and the data-memory
//               responder (slave). The err line exists only when
//               DMEM_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_responder_if;
  import dmem_pkg::*;

  logic [c_DATA_W-1:0] addr;
  logic                ren;
  logic                wen;
  logic [c_DATA_W-1:0] din;
  logic [3:0]          byte_select;
  logic [c_DATA_W-1:0] dout;
  logic                mem_ready;
`ifdef DMEM_ERR_EN
  logic                err;

  modport master (output addr, ren, wen, din, byte_select,
                  input  dout, mem_ready, err);
  modport slave  (input  addr, ren, wen, din, byte_select,
                  output dout, mem_ready, err);
`else
  modport master (output addr, ren, wen, din, byte_select,
                  input  dout, mem_ready);
  modport slave  (input  addr, ren, wen, din, byte_select,
                  output dout, mem_ready);
`endif

endinterface

`default_nettype wire

// File: rtl/dmem_bram.sv
// ============================================================================
// Module      : dmem_bram
// Description : Synchronous single-port RAM, DEPTH_WORDS x 32, four byte
//               write enables, registered read port that holds its value
//               until the next read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [3:0]          be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [c_DATA_W-1:0] wdata_i,
  output logic [c_DATA_W-1:0] rdata_o
);

  logic [c_DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [c_DATA_W-1:0] rdata_q;

  // Byte-lane write; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read register only updates on a read, so it holds across writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : CPU data-memory responder with programmable wait states.
//               IDLE accepts a request, WAIT burns WAIT_CYCLES cycles, DONE
//               is the one-cycle completion. The RAM is accessed on the edge
//               that enters DONE. Define DMEM_ERR_EN to enable out-of-range
//               and read+write error detection on the err line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  data_mem_responder_if.slave  bus
);

  localparam int c_IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [c_CNT_W-1:0] c_WAIT_INIT =
    (WAIT_CYCLES > 0) ? c_CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e              state_q;
  logic [c_CNT_W-1:0]  cnt_q;
  logic [c_DATA_W-1:0] addr_q;
  logic [c_DATA_W-1:0] din_q;
  logic [3:0]          be_q;
  logic                ren_q;
  logic                wen_q;
  logic                err_q;
  logic                zero_q;   // last completed read was an error: dout reads 0

  logic                w_req;
  logic                w_go;     // this edge enters DONE
  logic [c_DATA_W-1:0] w_addr;
  logic [c_DATA_W-1:0] w_din;
  logic [3:0]          w_be;
  logic                w_ren;
  logic                w_wen;
  logic                w_err;
  logic                w_ram_en;
  logic [c_DATA_W-1:0] w_rdata;
  logic                w_unused;

  assign w_req = bus.ren | bus.wen;

  // With no wait states DONE is entered straight from IDLE, so the RAM must
  // see the live bus request; otherwise it sees the latched request.
  generate
    if (WAIT_CYCLES == 0) begin : g_zero_wait
      assign w_go   = (state_q == ST_IDLE) && w_req;
      assign w_addr = bus.addr;
      assign w_din  = bus.din;
      assign w_be   = bus.byte_select;
      assign w_ren  = bus.ren;
      assign w_wen  = bus.wen;
    end else begin : g_wait
      assign w_go   = (state_q == ST_WAIT) && (cnt_q == '0);
      assign w_addr = addr_q;
      assign w_din  = din_q;
      assign w_be   = be_q;
      assign w_ren  = ren_q;
      assign w_wen  = wen_q;
    end
  endgenerate

`ifdef DMEM_ERR_EN
  assign w_err   = (|w_addr[c_DATA_W-1:c_IDX_W+2]) | (w_ren & w_wen);
  assign bus.err = err_q;
`else
  assign w_err   = 1'b0;
`endif

  // An erroring access never touches the RAM; read+write is a write.
  assign w_ram_en = w_go & ~w_err;

  dmem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (c_IDX_W)
  ) u_bram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (w_ram_en),
    .we_i    (w_wen),
    .be_i    (w_be),
    .addr_i  (w_addr[c_IDX_W+1:2]),
    .wdata_i (w_din),
    .rdata_o (w_rdata)
  );

  assign bus.mem_ready = ((state_q == ST_IDLE) && !w_req) || (state_q == ST_DONE);
  assign bus.dout      = zero_q ? '0 : w_rdata;

  // Low-order address bits and (in some builds) the latches are not
  // otherwise observed.
  assign w_unused = ^{w_addr, addr_q, din_q, be_q, ren_q, wen_q, err_q};

  // Request FSM: accept, count wait states, complete for one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      err_q <= w_go & w_err;
      if (w_go) begin
        if (w_err && w_ren) begin
          zero_q <= 1'b1;
        end else if (w_ren && !w_wen) begin
          zero_q <= 1'b0;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (w_req) begin
            addr_q <= bus.addr;
            din_q  <= bus.din;
            be_q   <= bus.byte_select;
            ren_q  <= bus.ren;
            wen_q  <= bus.wen;
            if (WAIT_CYCLES > 0) begin
              state_q <= ST_WAIT;
              cnt_q   <= c_WAIT_INIT;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - c_CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. Two instances
//               (WAIT_CYCLES=2 and WAIT_CYCLES=0) share clock and reset.
//               Expected values come from a word-addressed memory model.
//               DMEM_ERR_EN selects the error-checking expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int IDX_W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder_if if2();
  data_mem_responder_if if0();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut2 (
    .clk_i (clk), .rst_ni (rst_n), .bus (if2)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i (clk), .rst_ni (rst_n), .bus (if0)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl2 [int];
  logic [31:0] mdl0 [int];
  logic [31:0] last_dout [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic r, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (w == 2) begin
      if2.ren = r; if2.wen = wr; if2.addr = a; if2.din = d; if2.byte_select = be;
    end else begin
      if0.ren = r; if0.wen = wr; if0.addr = a; if0.din = d; if0.byte_select = be;
    end
  endtask

  function automatic logic get_ready(input int w);
    return (w == 2) ? if2.mem_ready : if0.mem_ready;
  endfunction

  function automatic logic [31:0] get_dout(input int w);
    return (w == 2) ? if2.dout : if0.dout;
  endfunction

`ifdef DMEM_ERR_EN
  function automatic logic get_err(input int w);
    return (w == 2) ? if2.err : if0.err;
  endfunction
`endif

  function automatic bit mdl_has(input int w, input int idx);
    return (w == 2) ? mdl2.exists(idx) : mdl0.exists(idx);
  endfunction

  function automatic logic [31:0] mdl_get(input int w, input int idx);
    if (w == 2) return mdl2.exists(idx) ? mdl2[idx] : 32'h0;
    return mdl0.exists(idx) ? mdl0[idx] : 32'h0;
  endfunction

  function automatic void mdl_put(input int w, input int idx, input logic [31:0] v);
    if (w == 2) mdl2[idx] = v;
    else        mdl0[idx] = v;
  endfunction

  // One full access from IDLE; called just after a rising edge.
  task automatic access(input int w, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input string tag);
    int          idx;
    int          k;
    int          lat;
    bit          exp_err;
    logic [31:0] exp_dout;
    logic [31:0] word;
    k   = (w == 2) ? 1 : 0;
    idx = int'((a >> 2) & 32'(DEPTH - 1));
`ifdef DMEM_ERR_EN
    exp_err = ((a >> (IDX_W + 2)) != 32'h0) || (rd && wr);
`else
    exp_err = 1'b0;
`endif
    exp_dout = last_dout[k];
    if (exp_err) begin
      if (rd) exp_dout = 32'h0;
    end else if (wr) begin
      word = mdl_get(w, idx);
      for (int b = 0; b < 4; b++) begin
        if (be[b]) word[8*b +: 8] = d[8*b +: 8];
      end
      mdl_put(w, idx, word);
    end else if (rd) begin
      exp_dout = mdl_get(w, idx);
    end
    last_dout[k] = exp_dout;

    drive(w, rd, wr, a, d, be);
    @(negedge clk);
    check({tag, "/accept_ready"}, {31'b0, get_ready(w)}, 32'd0);
`ifdef DMEM_ERR_EN
    check({tag, "/accept_err"}, {31'b0, get_err(w)}, 32'd0);
`endif
    @(posedge clk);
    #1;
    drive(w, 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
    lat = 1;
    @(negedge clk);
    while (get_ready(w) !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    drive(w, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check({tag, "/latency"}, 32'(lat), 32'(1 + w));
    check({tag, "/dout"}, get_dout(w), exp_dout);
`ifdef DMEM_ERR_EN
    check({tag, "/done_err"}, {31'b0, get_err(w)}, {31'b0, exp_err});
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          idx;
    int          w;
    bit          rd;
    bit          wr;
    logic [3:0]  be;

    last_dout[0] = 32'h0;
    last_dout[1] = 32'h0;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("reset/ready2", {31'b0, if2.mem_ready}, 32'd1);
    check("reset/dout2",  if2.dout, 32'h0);
    check("reset/ready0", {31'b0, if0.mem_ready}, 32'd1);
    check("reset/dout0",  if0.dout, 32'h0);
`ifdef DMEM_ERR_EN
    check("reset/err2", {31'b0, if2.err}, 32'd0);
`endif

    // Two wait states: full write, read back, partial and empty-mask writes
    access(2, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, "w2_full");
    access(2, 1, 0, 32'h10, 32'h0,        4'h0, "r2_full");
    access(2, 0, 1, 32'h10, 32'h000000AA, 4'h1, "w2_partial");
    access(2, 1, 0, 32'h10, 32'h0,        4'h0, "r2_partial");
    access(2, 0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, "w2_nomask");
    access(2, 1, 0, 32'h10, 32'h0,        4'h0, "r2_nomask");

    // Zero wait states: back-to-back reads
    access(0, 0, 1, 32'h0, 32'h11111111, 4'hF, "w0_a");
    access(0, 0, 1, 32'h4, 32'h22222222, 4'hF, "w0_b");
    access(0, 1, 0, 32'h0, 32'h0,        4'h0, "r0_a");
    access(0, 1, 0, 32'h4, 32'h0,        4'h0, "r0_b");

    // Out-of-range address: error build reports err and 0, default aliases
    access(0, 1, 0, 32'h00001000, 32'h0, 4'h0, "r0_alias");
`ifndef DMEM_ERR_EN
    access(0, 1, 1, 32'h4, 32'h33333333, 4'hF, "rw0_both");
    access(0, 1, 0, 32'h4, 32'h0,        4'h0, "r0_after_both");
`endif

    // Reset during the wait of a write aborts it
    access(2, 0, 1, 32'h20, 32'hCAFEF00D, 4'hF, "w2_prior");
    drive(2, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF);
    @(negedge clk);
    @(posedge clk);
    #1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_wait/ready2", {31'b0, if2.mem_ready}, 32'd1);
    check("rst_wait/dout2",  if2.dout, 32'h0);
    last_dout[0] = 32'h0;
    last_dout[1] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(2, 1, 0, 32'h20, 32'h0, 4'h0, "rst_wait/read");

    // Randomized accesses on both instances
    for (int i = 0; i < 48; i++) begin
      w   = (i % 2 == 0) ? 2 : 0;
      a   = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 12);
      idx = int'((a >> 2) & 32'(DEPTH - 1));
      if (!mdl_has(w, idx)) begin
        rd = 1'b0; wr = 1'b1; be = 4'hF;
      end else begin
        rd = 1'($urandom); wr = !rd; be = 4'($urandom);
      end
      access(w, rd, wr, a, $urandom, be, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
